// File: rtl/hz_pkg.sv
// hz_pkg: shared definitions for the hazard/stall scheduler.
//   hz_state_e  - registered cycle class reported on hz_state (RUN/LDUSE/IMISS/DMISS)
//   hz_class_e  - combinational cycle class, including branch redirect
//   CV_*        - bit positions within the pipeline control vector
//   ctrl_for()  - control vector for a given cycle class
//   state_for() - hz_state value loaded for a given cycle class
package hz_pkg;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_LDUSE = 2'd1,
        HZ_IMISS = 2'd2,
        HZ_DMISS = 2'd3
    } hz_state_e;

    typedef enum logic [2:0] {
        CLS_RUN,
        CLS_LDUSE,
        CLS_IMISS,
        CLS_DMISS,
        CLS_REDIR
    } hz_class_e;

    localparam int unsigned CV_PC_W   = 0;
    localparam int unsigned CV_IFID_W = 1;
    localparam int unsigned CV_IFID_F = 2;
    localparam int unsigned CV_IDEX_W = 3;
    localparam int unsigned CV_IDEX_F = 4;
    localparam int unsigned CV_EXM_W  = 5;
    localparam int unsigned CV_MWB_W  = 6;
    localparam int unsigned CV_WIDTH  = 7;

    typedef logic [CV_WIDTH-1:0] ctrl_vec_t;

    function automatic ctrl_vec_t ctrl_for(hz_class_e c);
        ctrl_vec_t v;
        v = '0;
        case (c)
            CLS_RUN: begin
                v[CV_PC_W]   = 1'b1;
                v[CV_IFID_W] = 1'b1;
                v[CV_IDEX_W] = 1'b1;
                v[CV_EXM_W]  = 1'b1;
                v[CV_MWB_W]  = 1'b1;
            end
            CLS_REDIR: begin
                v = '1;
            end
            CLS_IMISS: begin
                // Front end holds, IF/ID gets a bubble, back end drains.
                v[CV_IFID_F] = 1'b1;
                v[CV_IDEX_W] = 1'b1;
                v[CV_EXM_W]  = 1'b1;
                v[CV_MWB_W]  = 1'b1;
            end
            CLS_LDUSE: begin
                v[CV_IDEX_W] = 1'b1;
                v[CV_IDEX_F] = 1'b1;
                v[CV_EXM_W]  = 1'b1;
                v[CV_MWB_W]  = 1'b1;
            end
            CLS_DMISS: begin
                v = '0;
            end
            default: begin
                v = '0;
            end
        endcase
        return v;
    endfunction

    function automatic hz_state_e state_for(hz_class_e c);
        case (c)
            CLS_LDUSE: return HZ_LDUSE;
            CLS_IMISS: return HZ_IMISS;
            CLS_DMISS: return HZ_DMISS;
            default:   return HZ_RUN;
        endcase
    endfunction

endpackage

// File: rtl/hz_stall_timer.sv
// hz_stall_timer: watchdog for miss stalls.
//   clk           - clock
//   rst           - synchronous active-low reset
//   miss          - current cycle is an I-miss or D-miss stall
//   stall_timeout - sticky flag, set once TIMEOUT consecutive miss cycles have elapsed
// The counter advances on miss cycles, clears on any other cycle and saturates at TIMEOUT.
module hz_stall_timer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic miss,
    output logic stall_timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;
    logic        flag_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else if (miss) begin
            if (cnt_q != LIMIT) begin
                cnt_q <= cnt_q + 16'd1;
            end
            // Flag on the edge that brings the count to TIMEOUT.
            if (cnt_q >= LIMIT - 16'd1) begin
                flag_q <= 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign stall_timeout = flag_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline scheduler for the 5-stage MIPS core.
// Classifies each cycle (D-miss > redirect > I-miss > load-use > run) and drives
// PC / pipeline-register write enables and flushes combinationally; hz_state is the
// registered class. A watchdog (hz_stall_timer) flags miss stalls that never end.
// Ports:
//   clk, rst (sync, active-low)
//   ID_Rs, ID_Rt, ID_UsesRt        - source operands of the ID instruction
//   EX_MemRead, EX_WR_out          - EX instruction is a load / its destination
//   EX_BranchTaken                 - taken branch resolved in EX
//   IC_stall, DC_stall             - cache miss pending (level)
//   PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Write, M_WB_Write
//   hz_state                       - 0 RUN, 1 LDUSE, 2 IMISS, 3 DMISS
//   stall_timeout                  - sticky watchdog error
// Build option HZ_PERF_CNT_EN: adds cnt_lduse, cnt_imiss, cnt_dmiss, cnt_flush (CNT_W bits,
// saturating cycle counters).
import hz_pkg::*;

module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT = 1023
`ifdef HZ_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_WR_out,
    input  logic       EX_BranchTaken,
    input  logic       IC_stall,
    input  logic       DC_stall,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Write,
    output logic       ID_EX_Flush,
    output logic       EX_M_Write,
    output logic       M_WB_Write,
    output logic [1:0] hz_state,
    output logic       stall_timeout
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_lduse,
    output logic [CNT_W-1:0] cnt_imiss,
    output logic [CNT_W-1:0] cnt_dmiss,
    output logic [CNT_W-1:0] cnt_flush
`endif
);

    hz_class_e cls;
    ctrl_vec_t ctrl;
    logic      ld_use;
    hz_state_e state_q;

    always_comb begin
        // $0 is hardwired to zero, so a load targeting it is never a hazard.
        ld_use = EX_MemRead && (EX_WR_out != 5'd0) &&
                 ((EX_WR_out == ID_Rs) || (ID_UsesRt && (EX_WR_out == ID_Rt)));

        if (DC_stall) begin
            cls = CLS_DMISS;
        end else if (EX_BranchTaken) begin
            cls = CLS_REDIR;
        end else if (IC_stall) begin
            cls = CLS_IMISS;
        end else if (ld_use) begin
            cls = CLS_LDUSE;
        end else begin
            cls = CLS_RUN;
        end

        if (!rst) begin
            ctrl            = '0;
            ctrl[CV_IFID_F] = 1'b1;
            ctrl[CV_IDEX_F] = 1'b1;
        end else begin
            ctrl = ctrl_for(cls);
        end
    end

    assign PCWrite     = ctrl[CV_PC_W];
    assign IF_ID_Write = ctrl[CV_IFID_W];
    assign IF_ID_Flush = ctrl[CV_IFID_F];
    assign ID_EX_Write = ctrl[CV_IDEX_W];
    assign ID_EX_Flush = ctrl[CV_IDEX_F];
    assign EX_M_Write  = ctrl[CV_EXM_W];
    assign M_WB_Write  = ctrl[CV_MWB_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_for(cls);
        end
    end

    assign hz_state = state_q;

    hz_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .miss          ((cls == CLS_IMISS) || (cls == CLS_DMISS)),
        .stall_timeout (stall_timeout)
    );

`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] lduse_q, imiss_q, dmiss_q, flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lduse_q <= '0;
            imiss_q <= '0;
            dmiss_q <= '0;
            flush_q <= '0;
        end else begin
            if (cls == CLS_LDUSE && lduse_q != '1) lduse_q <= lduse_q + 1'b1;
            if (cls == CLS_IMISS && imiss_q != '1) imiss_q <= imiss_q + 1'b1;
            if (cls == CLS_DMISS && dmiss_q != '1) dmiss_q <= dmiss_q + 1'b1;
            if (cls == CLS_REDIR && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign cnt_lduse = lduse_q;
    assign cnt_imiss = imiss_q;
    assign cnt_dmiss = dmiss_q;
    assign cnt_flush = flush_q;
`endif

endmodule
